// File: rtl/shearsort_cell_pkg.sv
// ---------------------------------------------------------------------------
// shearsort_cell_pkg
//
// Shared definitions for every cell of the shearsort mesh and for the mesh
// top that wires the cells together.
//   - FSM state encoding (IDLE / ROW_PH / COL_PH)
//   - phase-kind constants (row phase / column phase)
//   - phaseState(): maps a phase kind onto the FSM state that runs it
// ---------------------------------------------------------------------------
package shearsort_cell_pkg;

    // FSM state encoding, kept as plain constants so older mesh tops that
    // compare raw state bits keep working
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_ROW_PH = 2'd1;
    localparam logic [1:0] STATE_COL_PH = 2'd2;

    // Phase kind equals the LSB of the phase index: even phases sort rows,
    // odd phases sort columns
    localparam logic PHASE_KIND_ROW = 1'b0;
    localparam logic PHASE_KIND_COL = 1'b1;

    // Translate a phase kind into the FSM state that executes it
    function automatic logic [1:0] phaseState(input logic kind);
        return (kind == PHASE_KIND_COL) ? STATE_COL_PH : STATE_ROW_PH;
    endfunction

endpackage

// File: rtl/shearsort_cell_cmp_sel.sv
// ---------------------------------------------------------------------------
// cmp_sel
//
// Combinational compare-and-select for one odd-even transposition step.
// Unsigned compare; on equal keys the cell's own key is returned so a tie
// never moves data.
//
// Ports:
//   i_own      own key register value
//   i_partner  key of the neighbour this cell is paired with
//   i_keepMin  1 = keep the smaller key, 0 = keep the larger key
//   o_sel      selected key
// ---------------------------------------------------------------------------
module cmp_sel #(
    parameter int DATA_WIDTH = 10
) (
    input  logic [DATA_WIDTH-1:0] i_own,
    input  logic [DATA_WIDTH-1:0] i_partner,
    input  logic                  i_keepMin,
    output logic [DATA_WIDTH-1:0] o_sel
);

    logic w_partnerLess;
    logic w_partnerGreater;

    // Strict compares so that equal keys always fall through to i_own
    always_comb begin
        w_partnerLess    = (i_partner < i_own);
        w_partnerGreater = (i_partner > i_own);
        o_sel            = i_own;
        if (i_keepMin && w_partnerLess) begin
            o_sel = i_partner;
        end else if (!i_keepMin && w_partnerGreater) begin
            o_sel = i_partner;
        end
    end

endmodule

// File: rtl/shearsort_cell.sv
// ---------------------------------------------------------------------------
// shearsort_cell
//
// One processing element of a SQRT_N x SQRT_N shearsort mesh. Each cell holds
// a single key and, during a sort, repeatedly swaps-by-selection with one
// neighbour per cycle (odd-even transposition). Phases alternate row / column
// for 2*LOG_SQRT_N+1 phases of SQRT_N steps each, leaving the mesh sorted in
// snake order (even rows ascending left->right, odd rows descending).
//
// Ports:
//   clk, rst            clock (rising edge) and async active-high reset
//   start               one-cycle request to begin a sort (IDLE only)
//   load_en, load_data  load a new key (IDLE only)
//   i_PE_l/r/u/d        neighbour keys (left, right, up, down)
//   o_PE                this cell's current key
//   busy                high while a sort runs
//   done                one-cycle pulse after the last step
// ---------------------------------------------------------------------------
module shearsort_cell
    import shearsort_cell_pkg::*;
#(
    parameter int SQRT_N     = 32,
    parameter int LOG_SQRT_N = 5,
    parameter int ROW        = 0,
    parameter int COL        = 0,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [DATA_WIDTH-1:0] i_PE_l,
    input  logic [DATA_WIDTH-1:0] i_PE_r,
    input  logic [DATA_WIDTH-1:0] i_PE_u,
    input  logic [DATA_WIDTH-1:0] i_PE_d,
    output logic [DATA_WIDTH-1:0] o_PE,
    output logic                  busy,
    output logic                  done
);

    // Phase index runs 0..2*LOG_SQRT_N, which always fits in LOG_SQRT_N+1 bits
    localparam int PHASE_W = LOG_SQRT_N + 1;

    localparam logic [LOG_SQRT_N-1:0] LAST_STEP  = LOG_SQRT_N'(SQRT_N - 1);
    localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(2 * LOG_SQRT_N);

    localparam logic COL_ODD   = 1'(COL % 2);
    localparam logic ROW_ODD   = 1'(ROW % 2);
    localparam logic HAS_LEFT  = (COL > 0);
    localparam logic HAS_RIGHT = (COL < SQRT_N - 1);
    localparam logic HAS_UP    = (ROW > 0);
    localparam logic HAS_DOWN  = (ROW < SQRT_N - 1);

    logic [1:0]            r_state;
    logic [LOG_SQRT_N-1:0] r_step;
    logic [PHASE_W-1:0]    r_phase;
    logic [DATA_WIDTH-1:0] r_key;
    logic                  r_done;

    logic                  w_rowEven;
    logic                  w_colEven;
    logic                  w_partnerValid;
    logic                  w_partnerHigh;
    logic                  w_keepMin;
    logic [DATA_WIDTH-1:0] w_partner;
    logic [DATA_WIDTH-1:0] w_selKey;

    // Pairing parity: only the LSBs of (COL+step) / (ROW+step) matter
    assign w_rowEven = ~(COL_ODD ^ r_step[0]);
    assign w_colEven = ~(ROW_ODD ^ r_step[0]);

    // Partner selection. w_partnerHigh marks the partner as the right/down
    // neighbour; the cell nearer the low-index end of an ascending line keeps
    // the minimum. Odd rows sort descending, hence the ROW_ODD flip.
    always_comb begin
        w_partnerValid = 1'b0;
        w_partnerHigh  = 1'b0;
        w_partner      = r_key;
        w_keepMin      = 1'b0;
        if (r_state == STATE_ROW_PH) begin
            if (w_rowEven) begin
                if (HAS_RIGHT) begin
                    w_partnerValid = 1'b1;
                    w_partnerHigh  = 1'b1;
                    w_partner      = i_PE_r;
                end
            end else if (HAS_LEFT) begin
                w_partnerValid = 1'b1;
                w_partner      = i_PE_l;
            end
            w_keepMin = w_partnerHigh ^ ROW_ODD;
        end else if (r_state == STATE_COL_PH) begin
            if (w_colEven) begin
                if (HAS_DOWN) begin
                    w_partnerValid = 1'b1;
                    w_partnerHigh  = 1'b1;
                    w_partner      = i_PE_d;
                end
            end else if (HAS_UP) begin
                w_partnerValid = 1'b1;
                w_partner      = i_PE_u;
            end
            w_keepMin = w_partnerHigh;
        end
    end

    cmp_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmpSel (
        .i_own     (r_key),
        .i_partner (w_partner),
        .i_keepMin (w_keepMin),
        .o_sel     (w_selKey)
    );

    // Sequencer: IDLE handles load/start; the sorting states step through
    // SQRT_N compare steps per phase and hop between row and column phases
    // by phase-index parity. done is registered so it lands the cycle after
    // the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STATE_IDLE;
            r_step  <= '0;
            r_phase <= '0;
            r_key   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                STATE_IDLE: begin
                    if (load_en) begin
                        r_key <= load_data;
                    end
                    if (start) begin
                        r_state <= STATE_ROW_PH;
                        r_step  <= '0;
                        r_phase <= '0;
                    end
                end
                STATE_ROW_PH, STATE_COL_PH: begin
                    if (w_partnerValid) begin
                        r_key <= w_selKey;
                    end
                    if (r_step == LAST_STEP) begin
                        r_step <= '0;
                        if (r_phase == LAST_PHASE) begin
                            r_state <= STATE_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_phase <= r_phase + PHASE_W'(1);
                            r_state <= phaseState(~r_phase[0]);
                        end
                    end else begin
                        r_step <= r_step + LOG_SQRT_N'(1);
                    end
                end
                default: begin
                    r_state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign o_PE = r_key;
    assign busy = (r_state != STATE_IDLE);
    assign done = r_done;

endmodule
